// File: rtl/core_regfile_pkg.sv
// rtl/core_regfile_pkg.sv - shared types and defaults for the multi-port register file
package core_regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

endpackage

// File: rtl/core_regfile_mp_if.sv
// rtl/core_regfile_mp_if.sv - read/write/issue bus between the pipeline and the register file
interface core_regfile_mp_if
  import core_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic                      ready;
  logic [NRD-1:0][AW-1:0]    raddr;
  logic [NRD-1:0][XLEN-1:0]  rdata;
  logic [NRD-1:0]            rbusy;
  logic [NWR-1:0]            wen;
  logic [NWR-1:0][AW-1:0]    waddr;
  logic [NWR-1:0][XLEN-1:0]  wdata;
  logic                      iss_valid;
  logic [AW-1:0]             iss_addr;

  modport master (
    output raddr, wen, waddr, wdata, iss_valid, iss_addr,
    input  ready, rdata, rbusy
  );

  modport slave (
    input  raddr, wen, waddr, wdata, iss_valid, iss_addr,
    output ready, rdata, rbusy
  );

endinterface

// File: rtl/core_regfile_sb.sv
// rtl/core_regfile_sb.sv - pending-write scoreboard, one busy bit per register
module core_regfile_sb
  import core_regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [AW-1:0]          set_addr,
  input  logic [NWR-1:0]         clr_en,
  input  logic [NWR-1:0][AW-1:0] clr_addr,
  output logic [NREGS-1:0]       busy
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Set is applied after the clears so a newer producer stays outstanding.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (clr_en[j]) busy_d[clr_addr[j]] = 1'b0;
    end
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/core_regfile_mp.sv
// rtl/core_regfile_mp.sv - multi-port register file with post-reset clear and hazard scoreboard
// Optional write-to-read bypass when CORE_REGFILE_BYPASS_EN is defined.
module core_regfile_mp
  import core_regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  core_regfile_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic             ready_q, ready_d;
  logic [XLEN-1:0]  file_q [NREGS];
  logic [XLEN-1:0]  file_d [NREGS];
  logic             run;
  logic [NREGS-1:0] busy;
  logic [NWR-1:0]   sb_clr;
  logic [NRD-1:0][XLEN-1:0] rdata_c;
  logic [NRD-1:0]           rbusy_c;

  assign run    = (state_q == RF_RUN);
  assign sb_clr = bus.wen & {NWR{run}};

  // Ascending port order lets the highest-numbered port win on address collisions.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    file_d    = file_q;
    case (state_q)
      RF_CLEAR: begin
        file_d[clr_idx_q] = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end
      end
      RF_RUN: begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wen[j] && (bus.waddr[j] != '0)) file_d[bus.waddr[j]] = bus.wdata[j];
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      file_q    <= file_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata_c[i] = (bus.raddr[i] == '0) ? '0 : file_q[bus.raddr[i]];
      rbusy_c[i] = run & busy[bus.raddr[i]];
`ifdef CORE_REGFILE_BYPASS_EN
      if (run && (bus.raddr[i] != '0)) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wen[j] && (bus.waddr[j] == bus.raddr[i])) begin
            rdata_c[i] = bus.wdata[j];
            rbusy_c[i] = 1'b0;
          end
        end
      end
`endif
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.rbusy = rbusy_c;
  assign bus.ready = ready_q;

  core_regfile_sb #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.iss_valid & run),
    .set_addr (bus.iss_addr),
    .clr_en   (sb_clr),
    .clr_addr (bus.waddr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_core_regfile_mp.sv
// tb/tb_core_regfile_mp.sv - directed scoreboard bench for core_regfile_mp (NWR=2)
module tb_core_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

`ifdef CORE_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  core_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string           tag;
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int port, input int addr,
                           input logic [XLEN-1:0] data, input logic busy);
    exp_t e;
    bus.raddr[port] = AW'(addr);
    e.tag  = tag;
    e.port = port;
    e.data = data;
    e.busy = busy;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_data"}, 64'(bus.rdata[e.port]), 64'(e.data));
      chk({e.tag, "_busy"}, 64'(bus.rbusy[e.port]), 64'(e.busy));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen       = '0;
    bus.iss_valid = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [XLEN-1:0] d);
    bus.wen[port]   = 1'b1;
    bus.waddr[port] = AW'(addr);
    bus.wdata[port] = d;
  endtask

  initial begin
    rst           = 1'b0;
    bus.raddr     = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.iss_addr  = '0;
    idle();
    step();
    step();
    chk("rst_ready", 64'(bus.ready), 64'd0);
    expect_rd("rst_r0_p0", 0, 0, '0, 1'b0);
    expect_rd("rst_r0_p1", 1, 0, '0, 1'b0);
    drain();

    // Clear with writes and issues held active; restart after 10 cycles.
    rst = 1'b1;
    wr(0, 12, 32'h0000_FFFF);
    wr(1, 20, 32'h1111_2222);
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(12);
    repeat (10) step();
    chk("clr_mid_ready", 64'(bus.ready), 64'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      step();
      cnt++;
      if (bus.ready === 1'b1) break;
    end
    idle();
    chk("clr_len", 64'(cnt), 64'd32);

    for (int a = 1; a < NREGS; a++) begin
      expect_rd($sformatf("clr_zero_r%0d", a), 0, a, '0, 1'b0);
      drain();
    end

    step();
    wr(0, 5, 32'hDEAD_BEEF);
    step();
    idle();
    expect_rd("wr5", 0, 5, 32'hDEAD_BEEF, 1'b0);
    drain();

    step();
    wr(0, 0, 32'h0000_1234);
    expect_rd("wr0_same", 0, 0, '0, 1'b0);
    drain();
    step();
    idle();
    expect_rd("wr0_next", 0, 0, '0, 1'b0);
    drain();

    step();
    wr(0, 7, 32'h0000_AAAA);
    wr(1, 7, 32'h0000_5555);
    step();
    idle();
    expect_rd("dual7_p1", 1, 7, 32'h0000_5555, 1'b0);
    expect_rd("dual7_p0", 0, 7, 32'h0000_5555, 1'b0);
    drain();

    step();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(3);
    expect_rd("iss3_same", 1, 3, '0, 1'b0);
    drain();
    step();
    idle();
    expect_rd("iss3_next", 1, 3, '0, 1'b1);
    drain();

    step();
    bus.raddr[1] = '0;
    wr(0, 3, 32'h0000_0033);
    step();
    idle();
    expect_rd("clr3", 1, 3, 32'h0000_0033, 1'b0);
    drain();

    step();
    wr(0, 3, 32'h0000_0044);
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(3);
    step();
    idle();
    expect_rd("setwins3", 1, 3, 32'h0000_0044, 1'b1);
    drain();

    step();
    wr(1, 3, 32'h0000_0045);
    step();
    idle();
    expect_rd("clr3b", 1, 3, 32'h0000_0045, 1'b0);
    drain();

    step();
    bus.iss_valid = 1'b1;
    bus.iss_addr  = AW'(9);
    step();
    idle();
    expect_rd("iss9", 1, 9, '0, 1'b1);
    drain();

    step();
    wr(0, 9, 32'h0000_0077);
    wr(1, 0, 32'h0000_00AB);
    expect_rd("byp9", 1, 9, BYP ? 32'h0000_0077 : 32'h0, BYP ? 1'b0 : 1'b1);
    expect_rd("byp0", 0, 0, '0, 1'b0);
    drain();
    step();
    idle();
    expect_rd("post9", 1, 9, 32'h0000_0077, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_regfile_mp.md
Name: core_regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read core register file.
- Adds configurable read/write port counts, a hardware clear sequence after reset, and a per-register pending-write scoreboard for hazard detection.
- Sits between decode (read, issue) and writeback (write) in the core pipeline.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 1, number of write ports (1..4)
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
ready  output  1  high once the clear sequence has finished
raddr  input  NRD x AW  read addresses
rdata  output  NRD x XLEN  read data
rbusy  output  NRD  pending write outstanding for raddr[i]
wen  input  NWR  write enables
waddr  input  NWR x AW  write addresses
wdata  input  NWR x XLEN  write data
iss_valid  input  1  instruction issued that will write iss_addr
iss_addr  input  AW  destination of the issued instruction

Behaviour:
- FSM states: CLEAR and RUN.
- Reset:
  - While rst==0 at a clock edge: state<=CLEAR, clr_idx<=0, busy<=0, ready<=0.
  - rst asserted mid-clear or mid-run restarts the clear sequence from index 0.
- CLEAR:
  - Each cycle writes 0 to file[clr_idx], then increments clr_idx.
  - After writing index NREGS-1: state<=RUN, ready<=1.
  - The sequence takes exactly NREGS cycles after rst deasserts.
  - wen and iss_valid are ignored. rdata reads the array as-is. rbusy=0.
- RUN, writes:
  - Each port with wen[j] writes wdata[j] to file[waddr[j]] at the clock edge.
  - Writes to register 0 are discarded.
  - Same address on several active ports: the highest-numbered port wins.
- RUN, reads:
  - Combinational, zero latency.
  - raddr==0 returns 0.
  - Otherwise returns the stored value, or the bypass value when CORE_REGFILE_BYPASS_EN is defined.
- Scoreboard (RUN only):
  - iss_valid sets busy[iss_addr].
  - Any wen[j] clears busy[waddr[j]].
  - Set and clear on the same address in the same cycle: set wins (a newer producer is outstanding).
  - busy[0] is always 0.
  - rbusy[i] = busy[raddr[i]], taken combinationally from the registered busy vector (not forwarded).
- Output reset values: ready=0, rbusy=0, rdata=0 for raddr 0. Other rdata values are undefined until clear completes.

Optional Feature:
CORE_REGFILE_BYPASS_EN
- Defined: write-to-read bypass.
  - If any wen[j] is active with waddr[j]==raddr[i]!=0 in RUN, rdata[i] returns the winning wdata in the same cycle.
  - rbusy[i] is forced to 0 for that read.
- Undefined: reads return the pre-edge array value. The new value is visible from the next cycle.

Decomposition:
- Package core_regfile_pkg holds:
  - the FSM enum rf_state_e {RF_CLEAR, RF_RUN};
  - localparam defaults XLEN_DEF=32, NREGS_DEF=32.
- One natural sub-module: core_regfile_sb, the busy-vector scoreboard with set/clear priority logic.
- Storage, write arbitration, bypass and the clear FSM stay in the top module.

Test Plan:
- Reset then release, NREGS=32:
  - ready stays 0 for exactly 32 cycles, then goes to 1.
  - Reading registers 1..31 returns 0.
  - rst pulsed at cycle 10 of the clear restarts the 32-cycle count.
- RUN, wen[0]=1, waddr=5, wdata=0xDEADBEEF:
  - Next cycle, raddr[0]=5 -> rdata[0]=0xDEADBEEF.
  - Write of 0x1234 to register 0 -> raddr=0 still reads 0.
- NWR=2, both ports write register 7 (0xAAAA on port 0, 0x5555 on port 1) -> register 7 reads 0x5555.
- Scoreboard sequence:
  - iss_valid, iss_addr=3 -> rbusy=1 for raddr=3 from the next cycle.
  - wen with waddr=3 -> rbusy=0 the next cycle.
  - iss_valid to 3 in the same cycle as wen to 3 -> busy stays 1.
- With CORE_REGFILE_BYPASS_EN, wen waddr=9 wdata=0x77 and raddr[1]=9 in the same cycle -> rdata[1]=0x77 combinationally, rbusy[1]=0.
- Without CORE_REGFILE_BYPASS_EN, same stimulus -> old value that cycle, 0x77 the next.
- Writes and iss_valid during CLEAR -> no effect: after ready, target registers read 0 and rbusy=0.
